// File: rtl/i2c_pkg.sv
// Shared I2C constants, PHY state encoding and address-match helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package i2c_pkg;

  localparam int I2C_DATA_WIDTH           = 8;
  localparam int I2C_ADDR_WIDTH           = 7;
  localparam int I2C_FILTER_DEPTH_DEFAULT = 3;
  localparam int I2C_BITS_PER_BYTE        = 8;

  typedef enum logic [1:0] {
    PHY_IDLE   = 2'd0,
    PHY_RX     = 2'd1,
    PHY_ACK    = 2'd2,
    PHY_IGNORE = 2'd3
  } phy_state_t;

  // True when an address byte selects this target for a write (R/W bit = 0).
  function automatic logic addr_write_match(input logic [I2C_DATA_WIDTH-1:0] addr_byte,
                                            input logic [I2C_ADDR_WIDTH-1:0] dev_addr);
    return (addr_byte[I2C_DATA_WIDTH-1:1] == dev_addr) && !addr_byte[0];
  endfunction

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchroniser plus deglitch filter for one open-drain bus line; idles high.
// Latency: 2 + FILTER_DEPTH clk from raw pin change to filtered output change.
// Backpressure: none; free-running sampler, pulses shorter than FILTER_DEPTH are absorbed.
module i2c_sync_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_DEPTH = I2C_FILTER_DEPTH_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt
);

  logic [1:0] sync_q;
  logic [3:0] cnt_q;

  // Metastability guard: raw pad into the clk domain, reset to the idle-high level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Accept a new level only after FILTER_DEPTH consecutive samples disagree with the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt  <= 1'b1;
      cnt_q <= 4'd0;
    end else if (sync_q[1] == filt) begin
      cnt_q <= 4'd0;
    end else if (cnt_q == 4'(FILTER_DEPTH - 1)) begin
      filt  <= sync_q[1];
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/i2c_target_phy.sv
// Write-only I2C target bit engine: START/STOP detect, MSB-first byte shift, ACK/NACK drive.
// Latency: strobes 1 clk after the filtered bus edge (3 + FILTER_DEPTH clk after the pin edge).
// Backpressure: none; the bus master sets the pace, strobes are single-cycle and never stall.
module i2c_target_phy
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] DEVICE_ADDR  = 7'h40,
  parameter int                        FILTER_DEPTH = I2C_FILTER_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe,
  output logic                      start,
  output logic                      stop,
  output logic                      rx_valid,
  output logic [I2C_DATA_WIDTH-1:0] rx_data,
  output logic                      busy
);

  logic scl_f, sda_f;
  logic scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  phy_state_t                state_q, state_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic                      byte_idx_q, byte_idx_d;
  logic                      byte_done_q, byte_done_d;
  logic [I2C_DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [I2C_DATA_WIDTH-1:0] rx_data_d;
  logic [I2C_DATA_WIDTH-1:0] new_byte;
  logic                      sda_oe_d, busy_d, start_d, stop_d, rx_valid_d;

  i2c_sync_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (scl_i),
    .filt    (scl_f)
  );

  i2c_sync_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (sda_i),
    .filt    (sda_f)
  );

  // Previous filtered levels for edge detection; idle bus is high on both lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  =  scl_f & ~scl_q;
  assign scl_fall  = ~scl_f &  scl_q;
  assign start_det =  scl_f &  sda_q & ~sda_f;
  assign stop_det  =  scl_f & ~sda_q &  sda_f;
  assign new_byte  = {shreg_q[I2C_DATA_WIDTH-2:0], sda_f};

  // Next-state and output decode; bus conditions outrank any same-cycle SCL edge.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    byte_done_d = byte_done_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data;
    sda_oe_d    = sda_oe;
    busy_d      = busy;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    rx_valid_d  = 1'b0;

    if (start_det) begin
      state_d     = PHY_RX;
      bit_cnt_d   = 4'd0;
      byte_idx_d  = 1'b0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      start_d     = 1'b1;
    end else if (stop_det) begin
      state_d     = PHY_IDLE;
      bit_cnt_d   = 4'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      stop_d      = 1'b1;
    end else begin
      case (state_q)
        PHY_RX: begin
          if (scl_rise && !byte_done_q) begin
            shreg_d = new_byte;
            if (bit_cnt_q == 4'(I2C_BITS_PER_BYTE - 1)) begin
              rx_data_d   = new_byte;
              rx_valid_d  = 1'b1;
              bit_cnt_d   = 4'd0;
              byte_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (scl_fall && byte_done_q) begin
            // SCL low after the 8th bit: decide ACK vs NACK for the 9th clock.
            byte_done_d = 1'b0;
            byte_idx_d  = 1'b1;
            if (!byte_idx_q && !addr_write_match(shreg_q, DEVICE_ADDR)) begin
              sda_oe_d = 1'b0;
              state_d  = PHY_IGNORE;
            end else begin
              sda_oe_d = 1'b1;
              state_d  = PHY_ACK;
            end
          end
        end
        PHY_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = PHY_RX;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, datapath and strobe registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PHY_IDLE;
      bit_cnt_q   <= 4'd0;
      byte_idx_q  <= 1'b0;
      byte_done_q <= 1'b0;
      shreg_q     <= '0;
      rx_data     <= '0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      start       <= 1'b0;
      stop        <= 1'b0;
      rx_valid    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      byte_done_q <= byte_done_d;
      shreg_q     <= shreg_d;
      rx_data     <= rx_data_d;
      sda_oe      <= sda_oe_d;
      busy        <= busy_d;
      start       <= start_d;
      stop        <= stop_d;
      rx_valid    <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_i2c_target_phy.sv
// Bench for i2c_target_phy: bit-banged I2C master, strobe monitor, table and random transactions.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_target_phy;
  import i2c_pkg::*;

  localparam int             FD   = 3;
  localparam logic [6:0]     ADDR = 7'h40;
  localparam int             Q    = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, start, stop, rx_valid, busy;
  logic [7:0] rx_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_phy #(.DEVICE_ADDR(ADDR), .FILTER_DEPTH(FD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .start    (start),
    .stop     (stop),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  logic [7:0] rx_q[$];

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (start)    start_cnt <= start_cnt + 1;
    if (stop)     stop_cnt  <= stop_cnt + 1;
    if (rx_valid) rx_q.push_back(rx_data);
  end

  typedef struct packed {
    logic [2:0]      n;
    logic [5:0][7:0] b;
    logic [2:0]      rs;         // index of byte preceded by repeated START, 0 = none
    logic [2:0]      exp_n;
    logic [5:0][7:0] exp_b;
    logic [5:0]      exp_ack;
    logic [1:0]      exp_starts;
  } vec_t;

  vec_t tab[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic do_rstart();
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(Q); sda_m = b;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(2 * Q); scl_m = 1'b0;
  endtask

  // Eight data bits, then release SDA and sample the target's drive in the 9th clock high.
  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); ack = sda_oe & ~sda_bus;
    wait_clk(Q); scl_m = 1'b0;
  endtask

  // Transaction-level reference: each START begins a new address phase; a rejected
  // address silences the rest of that segment; every accepted byte is ACKed.
  task automatic model(inout vec_t v);
    logic ign;
    logic first;
    v.exp_n = '0; v.exp_b = '0; v.exp_ack = '0; ign = 1'b0;
    v.exp_starts = (v.rs != 0) ? 2'd2 : 2'd1;
    for (int i = 0; i < int'(v.n); i++) begin
      first = (i == 0) || (v.rs != 0 && i == int'(v.rs));
      if (first) begin
        v.exp_b[v.exp_n] = v.b[i];
        v.exp_n          = v.exp_n + 3'd1;
        v.exp_ack[i]     = (v.b[i] >> 1) == 8'(ADDR) && v.b[i][0] == 1'b0;
        ign              = !v.exp_ack[i];
      end else if (!ign) begin
        v.exp_b[v.exp_n] = v.b[i];
        v.exp_n          = v.exp_n + 3'd1;
        v.exp_ack[i]     = 1'b1;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int         s0, p0, r0, got;
    logic       a;
    logic [5:0] acks;
    s0 = start_cnt; p0 = stop_cnt; r0 = rx_q.size(); acks = '0;
    do_start();
    for (int i = 0; i < int'(v.n); i++) begin
      if (v.rs != 0 && i == int'(v.rs)) do_rstart();
      send_byte(v.b[i], a);
      acks[i] = a;
      if (i == 0) chk({name, " busy_mid"}, busy, 1);
    end
    do_stop();
    wait_clk(4);
    got = rx_q.size() - r0;
    chk({name, " starts"}, start_cnt - s0, v.exp_starts);
    chk({name, " stops"}, stop_cnt - p0, 1);
    chk({name, " busy_end"}, busy, 0);
    chk({name, " rx_count"}, got, v.exp_n);
    for (int i = 0; i < int'(v.exp_n) && i < got; i++)
      chk($sformatf("%s rx_byte%0d", name, i), rx_q[r0 + i], v.exp_b[i]);
    for (int i = 0; i < int'(v.n); i++)
      chk($sformatf("%s ack%0d", name, i), acks[i], v.exp_ack[i]);
  endtask

  initial begin
    int   s0, p0;
    vec_t rv;

    // Reset values.
    wait_clk(3);
    chk("rst sda_oe", sda_oe, 0);
    chk("rst start", start, 0);
    chk("rst stop", stop, 0);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst rx_data", rx_data, 0);
    chk("rst busy", busy, 0);
    reset_n = 1'b1;
    wait_clk(10);

    // Hand-computed transaction table.
    for (int k = 0; k < 5; k++) tab[k] = '0;
    tab[0].n = 3; tab[0].b[0] = 8'h80; tab[0].b[1] = 8'h05; tab[0].b[2] = 8'hA5;
    tab[0].exp_n = 3; tab[0].exp_b[0] = 8'h80; tab[0].exp_b[1] = 8'h05; tab[0].exp_b[2] = 8'hA5;
    tab[0].exp_ack = 6'b000111; tab[0].exp_starts = 1;
    tab[1].n = 3; tab[1].b[0] = 8'h82; tab[1].b[1] = 8'h11; tab[1].b[2] = 8'h22;
    tab[1].exp_n = 1; tab[1].exp_b[0] = 8'h82; tab[1].exp_ack = 6'b000000; tab[1].exp_starts = 1;
    tab[2].n = 2; tab[2].b[0] = 8'h81; tab[2].b[1] = 8'h33;
    tab[2].exp_n = 1; tab[2].exp_b[0] = 8'h81; tab[2].exp_ack = 6'b000000; tab[2].exp_starts = 1;
    tab[3].n = 4; tab[3].rs = 2;
    tab[3].b[0] = 8'h80; tab[3].b[1] = 8'h10; tab[3].b[2] = 8'h80; tab[3].b[3] = 8'h20;
    tab[3].exp_n = 4; tab[3].exp_b[0] = 8'h80; tab[3].exp_b[1] = 8'h10;
    tab[3].exp_b[2] = 8'h80; tab[3].exp_b[3] = 8'h20; tab[3].exp_ack = 6'b001111; tab[3].exp_starts = 2;
    tab[4].n = 4; tab[4].rs = 2;
    tab[4].b[0] = 8'h82; tab[4].b[1] = 8'h55; tab[4].b[2] = 8'h80; tab[4].b[3] = 8'h66;
    tab[4].exp_n = 3; tab[4].exp_b[0] = 8'h82; tab[4].exp_b[1] = 8'h80; tab[4].exp_b[2] = 8'h66;
    tab[4].exp_ack = 6'b001100; tab[4].exp_starts = 2;
    for (int k = 0; k < 5; k++) run_vec(tab[k], $sformatf("vec%0d", k));

    // Randomised transactions against the reference model.
    for (int k = 0; k < 6; k++) begin
      rv = '0;
      rv.n = 3'($urandom_range(1, 4));
      for (int i = 0; i < int'(rv.n); i++) begin
        case ($urandom_range(0, 2))
          0:       rv.b[i] = {ADDR, 1'b0};
          1:       rv.b[i] = {ADDR, 1'b1};
          default: rv.b[i] = 8'($urandom);
        endcase
      end
      if (rv.n >= 3 && $urandom_range(0, 1) == 1) rv.rs = 3'($urandom_range(1, int'(rv.n) - 1));
      model(rv);
      run_vec(rv, $sformatf("rnd%0d", k));
    end

    // Glitch shorter than the filter is ignored; a long enough one is a real START.
    s0 = start_cnt; p0 = stop_cnt;
    wait_clk(2); sda_m = 1'b0;
    wait_clk(FD - 1); sda_m = 1'b1;
    wait_clk(20);
    chk("glitch_short start", start_cnt - s0, 0);
    chk("glitch_short stop", stop_cnt - p0, 0);
    sda_m = 1'b0;
    wait_clk(FD + 2); sda_m = 1'b1;
    wait_clk(20);
    chk("glitch_long start", start_cnt - s0, 1);

    // Reset mid-byte: outputs clear at once, no STOP strobe, then normal operation.
    do_start();
    for (int i = 7; i >= 4; i--) send_bit(tab[0].b[0][i]);
    chk("mid busy", busy, 1);
    p0 = stop_cnt;
    reset_n = 1'b0;
    #1;
    chk("mid_rst sda_oe", sda_oe, 0);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst rx_data", rx_data, 0);
    chk("mid_rst rx_valid", rx_valid, 0);
    chk("mid_rst start", start, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(10);
    reset_n = 1'b1;
    wait_clk(10);
    chk("mid_rst no_stop", stop_cnt - p0, 0);
    rv = '0; rv.n = 1; rv.b[0] = 8'h80;
    model(rv);
    run_vec(rv, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
